// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access unit.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned MAX_LAT    = 4;
  localparam int unsigned CNT_W      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module ram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR plus word RAM behind a Read/Write strobe with busy/done handshake
// and configurable read/write latency.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDRq,
  output logic [ADDR_W-1:0] MARq,
  output logic              busy,
  output logic              done
);

  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] addr_lat_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] data_lat_q;
  logic [CNT_W-1:0]  cnt_q;
  state_e            state_q;
  logic              busy_q;
  logic              done_q;

  logic              last_c;
  logic              rd_cmp_c;
  logic              wr_cmp_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_rdata;

  assign last_c   = (cnt_q == CNT_W'(1));
  assign rd_cmp_c = (state_q == ST_RD) && last_c;
  assign wr_cmp_c = (state_q == ST_WR) && last_c;

  // In IDLE the RAM reads at MAR so a read accepted now has data one edge later.
  assign ram_addr_c = (state_q == ST_IDLE) ? mar_q : addr_lat_q;

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_cmp_c),
    .addr  (ram_addr_c),
    .wdata (data_lat_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mar_q <= '0;
    end else if (MARin) begin
      mar_q <= BusMuxOut[ADDR_W-1:0];
    end
  end

  // Read completion overrides a bus load on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mdr_q <= '0;
    end else if (rd_cmp_c) begin
      mdr_q <= ram_rdata;
    end else if (MDRin) begin
      mdr_q <= BusMuxOut;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_lat_q <= '0;
      data_lat_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Write) begin
            state_q    <= ST_WR;
            cnt_q      <= CNT_W'(WR_LAT);
            addr_lat_q <= mar_q;
            data_lat_q <= mdr_q;
            busy_q     <= 1'b1;
          end else if (Read) begin
            state_q    <= ST_RD;
            cnt_q      <= CNT_W'(RD_LAT);
            addr_lat_q <= mar_q;
            data_lat_q <= mdr_q;
            busy_q     <= 1'b1;
          end
        end
        ST_RD, ST_WR: begin
          if (last_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MARq = mar_q;
  assign MDRq = mdr_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 9;
  localparam int unsigned RDL = 3;
  localparam int unsigned WRL = 4;

  logic          clk;
  logic          clr;
  logic [DW-1:0] BusMuxOut;
  logic          MARin;
  logic          MDRin;
  logic          Read;
  logic          Write;
  logic [DW-1:0] MDRq;
  logic [AW-1:0] MARq;
  logic          busy;
  logic          done;

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .RD_LAT (RDL),
    .WR_LAT (WRL)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .BusMuxOut (BusMuxOut),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .Read      (Read),
    .Write     (Write),
    .MDRq      (MDRq),
    .MARq      (MARq),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int done_seen = 0;

  // Reference model: architectural registers plus one pending transaction.
  logic [DW-1:0] m_mem [2**AW];
  logic [AW-1:0] m_mar;
  logic [DW-1:0] m_mdr;
  logic          m_busy;
  logic          m_done;
  logic          m_is_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_end;
  int            cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("marq", 32'(MARq), 32'(m_mar));
    check_eq("mdrq", MDRq, m_mdr);
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
  endtask

  task automatic step(input logic [DW-1:0] bus, input logic mi, input logic mdi,
                      input logic rd, input logic wr);
    logic [DW-1:0] nxt_mdr;
    logic          completing;
    @(negedge clk);
    BusMuxOut = bus;
    MARin     = mi;
    MDRin     = mdi;
    Read      = rd;
    Write     = wr;
    cyc++;
    completing = m_busy && (cyc == m_end);
    nxt_mdr    = mdi ? bus : m_mdr;
    if (completing) begin
      if (m_is_wr) m_mem[m_addr] = m_data;
      else         nxt_mdr = m_mem[m_addr];
      m_busy = 1'b0;
    end else if (!m_busy && (rd || wr)) begin
      m_busy  = 1'b1;
      m_is_wr = wr;
      m_addr  = m_mar;
      m_data  = m_mdr;
      m_end   = cyc + int'(wr ? WRL : RDL);
    end
    m_done = completing;
    if (mi) m_mar = bus[AW-1:0];
    m_mdr = nxt_mdr;
    @(posedge clk);
    #1;
    check_all();
    if (done) done_seen++;
  endtask

  task automatic idle();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_free();
    for (int i = 0; i < 8 && m_busy; i++) idle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    m_mar = '0; m_mdr = '0; m_busy = 1'b0; m_done = 1'b0;
    #1;
    check_eq("rst_marq", 32'(MARq), 32'h0);
    check_eq("rst_mdrq", MDRq, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    #2;
    clr = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(DW'(a), 1'b1, 1'b0, 1'b0, 1'b0);
    step(d, 1'b0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_free();
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    step(DW'(a), 1'b1, 1'b0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_free();
  endtask

  initial begin
    clr = 1'b0;
    BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_is_wr = 1'b0; m_addr = '0; m_data = '0; m_end = 0;
    m_mar = '0; m_mdr = '0;
    do_reset();

    // Give every address used below a known value.
    for (int a = 0; a < 16; a++) write_word(AW'(a), $urandom);

    // Write then read back.
    write_word(9'd0, 32'd12);
    step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    read_word(9'd0);
    check_eq("wr_rd", MDRq, 32'd12);

    // Read latency 3: MDR and done only at the third edge.
    write_word(9'd3, 32'h3333);
    step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rdlat_e0_busy", 32'(busy), 32'h1);
    idle();
    check_eq("rdlat_e1_busy", 32'(busy), 32'h1);
    idle();
    check_eq("rdlat_e2_mdr", MDRq, 32'h0);
    check_eq("rdlat_e2_done", 32'(done), 32'h0);
    idle();
    check_eq("rdlat_e3_busy", 32'(busy), 32'h0);
    check_eq("rdlat_e3_done", 32'(done), 32'h1);
    check_eq("rdlat_e3_mdr", MDRq, 32'h3333);

    // Second write while busy is ignored.
    step(32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    done_seen = 0;
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_free();
    idle(); idle(); idle();
    check_eq("busy_one_done", 32'(done_seen), 32'd1);
    read_word(9'd5);
    check_eq("busy_ram5", MDRq, 32'hAAAA);

    // Read+Write together: write wins, MDR not loaded from RAM.
    write_word(9'd7, 32'h0BAD);
    step(32'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_free();
    check_eq("rw_mdr", MDRq, 32'h55);
    step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    read_word(9'd7);
    check_eq("rw_ram7", MDRq, 32'h55);

    // Reset aborts an uncommitted write.
    write_word(9'd2, 32'h11);
    step(32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    do_reset();
    read_word(9'd2);
    check_eq("rst_ram2", MDRq, 32'h11);

    // Address wrap and MDR contention on the read-completion edge.
    write_word(9'd1, 32'h1234_5678);
    step(32'h0000_0201, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("mar_wrap", 32'(MARq), 32'h1);
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(); idle();
    step(32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("mdr_contend", MDRq, 32'h1234_5678);

    // Random traffic; MAR loads confined to the initialised addresses.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (i == 300) do_reset();
      step($urandom & 32'hFFFF_FE0F, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           r < 20, r >= 15 && r < 30);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
